// File: rtl/pre_if_stage_pkg.sv
// Shared widths, bus payloads and exception codes for the pre-IF fetch stage.
package pre_if_stage_pkg;

  localparam int unsigned PC_WD             = 32;
  localparam int unsigned ECODE_WD          = 6;
  localparam int unsigned PFS_TO_FS_BUS_WD  = 40;
  localparam int unsigned PFS_TO_MMU_BUS_WD = 32;
  localparam int unsigned MMU_TO_PFS_BUS_WD = 4;

  localparam logic [ECODE_WD-1:0] ECODE_ADE  = 6'h08;
  localparam logic [ECODE_WD-1:0] ECODE_PIF  = 6'h03;
  localparam logic [ECODE_WD-1:0] ECODE_PPI  = 6'h07;
  localparam logic [ECODE_WD-1:0] ECODE_TLBR = 6'h3f;

  typedef struct packed {
    logic                discard;
    logic                ex;
    logic [ECODE_WD-1:0] ecode;
    logic [PC_WD-1:0]    pc;
  } pfs_to_fs_t;

  typedef struct packed {
    logic adef;
    logic pif;
    logic ppi;
    logic tlbr;
  } mmu_to_pfs_t;

  // Highest-priority fetch fault wins: ADE, then TLB refill, then PIF, then PPI.
  function automatic logic [ECODE_WD-1:0] fetch_ecode(input mmu_to_pfs_t f);
    if (f.adef)      return ECODE_ADE;
    else if (f.tlbr) return ECODE_TLBR;
    else if (f.pif)  return ECODE_PIF;
    else if (f.ppi)  return ECODE_PPI;
    return '0;
  endfunction

endpackage

// File: rtl/pre_if_stage_if.sv
// Pre-IF stage bundle: redirect, IF handoff, mmu lookup and instruction SRAM request.
interface pre_if_stage_if;
  import pre_if_stage_pkg::*;

  logic                         redirect_valid;
  logic [PC_WD-1:0]             redirect_pc;
  logic                         fs_allowin;
  logic                         pfs_to_fs_valid;
  logic [PFS_TO_FS_BUS_WD-1:0]  pfs_to_fs_bus;
  logic [PFS_TO_MMU_BUS_WD-1:0] pfs_to_mmu_bus;
  logic [MMU_TO_PFS_BUS_WD-1:0] mmu_to_pfs_bus;
  logic [PC_WD-1:0]             inst_pa;
  logic                         inst_sram_req;
  logic [PC_WD-1:0]             inst_sram_addr;
  logic                         inst_sram_addr_ok;

  modport master (
    input  redirect_valid, redirect_pc, fs_allowin, mmu_to_pfs_bus, inst_pa, inst_sram_addr_ok,
    output pfs_to_fs_valid, pfs_to_fs_bus, pfs_to_mmu_bus, inst_sram_req, inst_sram_addr
  );

  modport slave (
    output redirect_valid, redirect_pc, fs_allowin, mmu_to_pfs_bus, inst_pa, inst_sram_addr_ok,
    input  pfs_to_fs_valid, pfs_to_fs_bus, pfs_to_mmu_bus, inst_sram_req, inst_sram_addr
  );

endinterface

// File: rtl/pre_if_stage.sv
// Pre-IF stage: owns the fetch PC, issues SRAM-like fetch requests and forwards fetch faults.
// Redirects arriving while a request is held are buffered so the handshake is never broken.
module pre_if_stage
  import pre_if_stage_pkg::*;
#(
  parameter logic [PC_WD-1:0] RESET_PC = 32'h1c00_0000
) (
  input  logic           clk,
  input  logic           resetn,
  pre_if_stage_if.master bus
);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_EXC   = 2'd2;
  localparam logic [1:0] S_STALL = 2'd3;

  logic [1:0]       r_state;
  logic [PC_WD-1:0] r_pc;
  logic [PC_WD-1:0] r_hold_addr;
  logic             r_rbuf_valid;
  logic [PC_WD-1:0] r_rbuf_pc;

  logic [1:0]       w_state_nxt;
  logic [PC_WD-1:0] w_pc_nxt;
  logic [PC_WD-1:0] w_hold_addr_nxt;
  logic             w_rbuf_valid_nxt;
  logic [PC_WD-1:0] w_rbuf_pc_nxt;
  logic             w_req;
  logic [PC_WD-1:0] w_addr;
  logic             w_fs_valid;
  logic             w_discard;
  logic             w_exc_out;
  logic             w_ex;
  logic [PC_WD-1:0] w_pc_inc;
  mmu_to_pfs_t      w_flags;
  pfs_to_fs_t       w_fs_bus;

  assign w_flags  = mmu_to_pfs_t'(bus.mmu_to_pfs_bus);
  assign w_ex     = |bus.mmu_to_pfs_bus;
  assign w_pc_inc = r_pc + PC_WD'(4);

  // Next-state, request and IF-handoff decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_hold_addr_nxt  = r_hold_addr;
    w_rbuf_valid_nxt = r_rbuf_valid;
    w_rbuf_pc_nxt    = r_rbuf_pc;
    w_req            = 1'b0;
    w_addr           = bus.inst_pa;
    w_fs_valid       = 1'b0;
    w_discard        = 1'b0;
    w_exc_out        = 1'b0;
    case (r_state)
      S_REQ: begin
        if (bus.redirect_valid) begin
          w_pc_nxt = bus.redirect_pc;
        end else if (w_ex) begin
          w_state_nxt = S_EXC;
        end else begin
          w_req = bus.fs_allowin;
          if (w_req && bus.inst_sram_addr_ok) begin
            w_fs_valid = 1'b1;
            w_pc_nxt   = w_pc_inc;
          end else if (w_req) begin
            w_hold_addr_nxt = bus.inst_pa;
            w_state_nxt     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // Request must stay stable until accepted, so redirects are only recorded here.
        w_req  = 1'b1;
        w_addr = r_hold_addr;
        if (bus.inst_sram_addr_ok) begin
          w_fs_valid       = 1'b1;
          w_discard        = r_rbuf_valid | bus.redirect_valid;
          w_rbuf_valid_nxt = 1'b0;
          w_state_nxt      = S_REQ;
          if (bus.redirect_valid)  w_pc_nxt = bus.redirect_pc;
          else if (r_rbuf_valid)   w_pc_nxt = r_rbuf_pc;
          else                     w_pc_nxt = w_pc_inc;
        end else if (bus.redirect_valid) begin
          w_rbuf_valid_nxt = 1'b1;
          w_rbuf_pc_nxt    = bus.redirect_pc;
        end
      end
      S_EXC: begin
        w_exc_out = 1'b1;
        if (bus.redirect_valid) begin
          w_pc_nxt    = bus.redirect_pc;
          w_state_nxt = S_REQ;
        end else if (bus.fs_allowin) begin
          w_fs_valid  = 1'b1;
          w_state_nxt = S_STALL;
        end
      end
      S_STALL: begin
        if (bus.redirect_valid) begin
          w_pc_nxt    = bus.redirect_pc;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_hold_addr  <= '0;
      r_rbuf_valid <= 1'b0;
      r_rbuf_pc    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_hold_addr  <= w_hold_addr_nxt;
      r_rbuf_valid <= w_rbuf_valid_nxt;
      r_rbuf_pc    <= w_rbuf_pc_nxt;
    end
  end

  always_comb begin
    w_fs_bus.discard = w_discard;
    w_fs_bus.ex      = w_exc_out;
    w_fs_bus.ecode   = w_exc_out ? fetch_ecode(w_flags) : '0;
    w_fs_bus.pc      = r_pc;
  end

  assign bus.pfs_to_fs_valid = w_fs_valid;
  assign bus.pfs_to_fs_bus   = PFS_TO_FS_BUS_WD'(w_fs_bus);
  assign bus.pfs_to_mmu_bus  = PFS_TO_MMU_BUS_WD'(r_pc);
  assign bus.inst_sram_req   = w_req;
  assign bus.inst_sram_addr  = w_addr;

endmodule

// File: tb/tb_pre_if_stage.sv
// Directed fetch scenarios followed by randomized traffic, checked against a transaction-level model.
module tb_pre_if_stage;
  import pre_if_stage_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  logic clk = 1'b0;
  logic resetn;
  pre_if_stage_if bus();

  pre_if_stage #(.RESET_PC(RESET_PC)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: current pc, an outstanding request (if any), redirects seen while it waits, trap progress.
  logic [31:0] m_pc;
  bit          m_busy;
  logic [31:0] m_busy_pa;
  logic [31:0] m_redir[$];
  bit          m_fault;
  bit          m_parked;
  logic [3:0]  flag_tbl[logic [31:0]];
  bit          rnd_flags;

  logic        obs_req;
  logic [31:0] obs_addr;
  logic        obs_valid;
  pfs_to_fs_t  obs_bus;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Fault codes by priority on flags {adef, pif, ppi, tlbr}.
  function automatic logic [5:0] ref_ecode(input logic [3:0] f);
    if (f[3]) return 6'h08;
    if (f[0]) return 6'h3f;
    if (f[2]) return 6'h03;
    if (f[1]) return 6'h07;
    return 6'h00;
  endfunction

  task automatic get_flags(input logic [31:0] pc, output logic [3:0] f);
    if (!flag_tbl.exists(pc))
      flag_tbl[pc] = (rnd_flags && $urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
    f = flag_tbl[pc];
  endtask

  task automatic drive_idle();
    bus.redirect_valid    = 1'b0;
    bus.redirect_pc       = '0;
    bus.fs_allowin        = 1'b0;
    bus.mmu_to_pfs_bus    = '0;
    bus.inst_pa           = '0;
    bus.inst_sram_addr_ok = 1'b0;
  endtask

  task automatic cycle(input bit rv, input logic [31:0] rpc, input bit al, input bit aok,
                       input logic [31:0] pa);
    logic [3:0]  f;
    bit          e_req, e_valid, e_disc, e_ex;
    logic [5:0]  e_ec;
    logic [31:0] e_addr, nxt_pc;
    get_flags(m_pc, f);
    bus.redirect_valid    = rv;
    bus.redirect_pc       = rpc;
    bus.fs_allowin        = al;
    bus.inst_sram_addr_ok = aok;
    bus.mmu_to_pfs_bus    = f;
    bus.inst_pa           = pa;
    #1;
    e_req = 0; e_addr = pa; e_valid = 0; e_disc = 0; e_ex = 0; e_ec = '0; nxt_pc = m_pc;
    if (m_busy) begin
      e_req = 1; e_addr = m_busy_pa;
      if (rv) m_redir.push_back(rpc);
      if (aok) begin
        e_valid = 1;
        e_disc  = (m_redir.size() != 0);
        nxt_pc  = e_disc ? m_redir[$] : m_pc + 32'd4;
        m_redir.delete();
        m_busy  = 0;
      end
    end else if (m_parked) begin
      if (rv) begin nxt_pc = rpc; m_parked = 0; end
    end else if (m_fault) begin
      e_ex = 1; e_ec = ref_ecode(f);
      if (rv) begin nxt_pc = rpc; m_fault = 0; end
      else if (al) begin e_valid = 1; m_fault = 0; m_parked = 1; end
    end else if (rv) begin
      nxt_pc = rpc;
    end else if (f != 4'h0) begin
      m_fault = 1;
    end else if (al) begin
      e_req = 1;
      if (aok) begin e_valid = 1; nxt_pc = m_pc + 32'd4; end
      else begin m_busy = 1; m_busy_pa = pa; end
    end
    obs_req   = bus.inst_sram_req;
    obs_addr  = bus.inst_sram_addr;
    obs_valid = bus.pfs_to_fs_valid;
    obs_bus   = pfs_to_fs_t'(bus.pfs_to_fs_bus);
    check("req", 64'(obs_req), 64'(e_req));
    if (e_req) check("addr", 64'(obs_addr), 64'(e_addr));
    check("fs_valid", 64'(obs_valid), 64'(e_valid));
    check("mmu_va", 64'(bus.pfs_to_mmu_bus), 64'(m_pc));
    check("bus_pc", 64'(obs_bus.pc), 64'(m_pc));
    if (e_valid) begin
      check("discard", 64'(obs_bus.discard), 64'(e_disc));
      check("ex", 64'(obs_bus.ex), 64'(e_ex));
      check("ecode", 64'(obs_bus.ecode), 64'(e_ec));
    end
    m_pc = nxt_pc;
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    drive_idle();
    #1;
    check("rst_req", 64'(bus.inst_sram_req), 64'd0);
    check("rst_valid", 64'(bus.pfs_to_fs_valid), 64'd0);
    check("rst_bus", 64'(bus.pfs_to_fs_bus), {24'h0, 1'b0, 1'b0, 6'h00, RESET_PC});
    repeat (2) @(negedge clk);
    resetn   = 1'b1;
    m_pc     = RESET_PC;
    m_busy   = 0;
    m_fault  = 0;
    m_parked = 0;
    m_redir.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          rv, al, aok;
    logic [31:0] rpc;
    resetn    = 1'b1;
    rnd_flags = 0;
    drive_idle();
    @(negedge clk);
    do_reset();

    // Back-to-back fetches from reset.
    for (int i = 0; i < 3; i++) begin
      cycle(0, '0, 1, 1, m_pc);
      check($sformatf("seq_addr%0d", i), 64'(obs_addr), 64'(RESET_PC + 32'(4 * i)));
    end
    cycle(0, '0, 1, 1, m_pc);

    // Held request survives a changing PA.
    cycle(0, '0, 1, 0, 32'h0000_0010);
    for (int i = 0; i < 3; i++) begin
      cycle(0, '0, 1, 0, $urandom());
      check("hold_addr", 64'(obs_addr), 64'h10);
    end
    cycle(0, '0, 1, 1, $urandom());
    check("hold_ack_valid", 64'(obs_valid), 64'd1);
    check("hold_next_va", 64'(bus.pfs_to_mmu_bus), 64'h1c00_0014);

    // Two redirects during HOLD: last one wins, entry discarded.
    cycle(0, '0, 1, 0, m_pc);
    cycle(1, 32'h1c00_0100, 1, 0, $urandom());
    cycle(1, 32'h1c00_0200, 1, 0, $urandom());
    cycle(0, '0, 1, 1, $urandom());
    check("rbuf_discard", 64'(obs_bus.discard), 64'd1);
    check("rbuf_target", 64'(bus.pfs_to_mmu_bus), 64'h1c00_0200);

    // PC wraps modulo 2^32.
    cycle(1, 32'hffff_fffc, 1, 1, m_pc);
    cycle(0, '0, 1, 1, m_pc);
    check("pc_wrap", 64'(bus.pfs_to_mmu_bus), 64'h0);

    // adef+tlbr fault: ADE code, then stall until redirect.
    flag_tbl[32'h1c00_0020] = 4'b1001;
    cycle(1, 32'h1c00_0020, 1, 1, m_pc);
    cycle(0, '0, 1, 1, m_pc);
    check("exc_no_req", 64'(obs_req), 64'd0);
    cycle(0, '0, 1, 1, m_pc);
    check("ade_ecode", 64'(obs_bus.ecode), 64'h08);
    cycle(0, '0, 1, 1, m_pc);
    cycle(0, '0, 1, 1, m_pc);
    check("stall_no_req", 64'(obs_req), 64'd0);
    cycle(1, 32'h1c00_8000, 1, 1, m_pc);
    cycle(0, '0, 1, 1, m_pc);
    check("post_trap_req", 64'(obs_addr), 64'h1c00_8000);

    // tlbr fault held back by fs_allowin, then redirect straight out of EXC.
    flag_tbl[32'h1c00_8004] = 4'b0001;
    flag_tbl[32'h1c00_9000] = 4'b0001;
    cycle(0, '0, 1, 1, m_pc);
    cycle(0, '0, 0, 1, m_pc);
    cycle(0, '0, 0, 1, m_pc);
    check("exc_wait_valid", 64'(obs_valid), 64'd0);
    cycle(0, '0, 1, 1, m_pc);
    check("tlbr_ecode", 64'(obs_bus.ecode), 64'h3f);
    cycle(1, 32'h1c00_9000, 1, 1, m_pc);
    cycle(0, '0, 1, 1, m_pc);
    cycle(1, 32'h1c00_a000, 1, 1, m_pc);
    check("exc_redir_quiet", 64'(obs_valid), 64'd0);
    check("exc_redir_pc", 64'(bus.pfs_to_mmu_bus), 64'h1c00_a000);

    // Reset in the middle of HOLD with a buffered redirect.
    cycle(0, '0, 1, 0, m_pc);
    cycle(1, 32'h1c00_b000, 1, 0, $urandom());
    do_reset();
    cycle(0, '0, 1, 0, m_pc);
    check("rst_restart_addr", 64'(obs_addr), 64'(RESET_PC));
    cycle(0, '0, 1, 1, $urandom());
    check("rst_rbuf_clear", 64'(obs_bus.discard), 64'd0);

    // Randomized traffic; IF keeps allowin high while a request is held.
    rnd_flags = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        rv  = ($urandom_range(0, 9) == 0);
        rpc = $urandom() & 32'hffff_fffc;
        al  = m_busy ? 1'b1 : ($urandom_range(0, 3) != 0);
        aok = 1'($urandom_range(0, 1));
        cycle(rv, rpc, al, aok, $urandom());
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
